// File: rtl/print_output_fifo.sv
// print_output_fifo: buffers print words from the output arbiter for the
// host, popping one word per host_ack rising edge; reports fill and overflow.
module print_output_fifo #(
   parameter int WIDTH = 32,
   parameter int DEPTH = 8,
   parameter int CNT_W = $clog2(DEPTH) + 1
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             print_hex_enable,
   input  logic [WIDTH-1:0] print_output,
   input  logic             host_ack,
   input  logic             host_clear,
   output logic [WIDTH-1:0] data_out,
   output logic             data_valid,
   output logic [CNT_W-1:0] fill_count,
   output logic             full,
   output logic             overflow
);

   localparam int PTR_W = $clog2(DEPTH);

   logic [WIDTH-1:0] mem_q [DEPTH];

   logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
   logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [WIDTH-1:0] dout_q, dout_d;
   logic             valid_q, valid_d;
   logic             full_q, full_d;
   logic             ovf_q, ovf_d;
   logic             ack_q, ack_d;

   logic pop_req;
   logic pop;
   logic push;
   logic wr_en;

   // Next-state: ack edge detect, push/pop arbitration, flush, head lookahead
   always_comb begin
      ack_d    = host_ack;
      pop_req  = host_ack & ~ack_q;
      pop      = pop_req & valid_q;
      push     = print_hex_enable & (~full_q | pop);
      wr_en    = push & ~host_clear;
      rd_ptr_d = rd_ptr_q;
      wr_ptr_d = wr_ptr_q;
      cnt_d    = cnt_q;
      dout_d   = dout_q;
      valid_d  = valid_q;
      full_d   = full_q;
      ovf_d    = ovf_q;
      if (host_clear) begin
         rd_ptr_d = '0;
         wr_ptr_d = '0;
         cnt_d    = '0;
         valid_d  = 1'b0;
         full_d   = 1'b0;
         ovf_d    = 1'b0;
      end else begin
         if (pop)
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
         if (push)
            wr_ptr_d = wr_ptr_q + PTR_W'(1);
         if (push && !pop)
            cnt_d = cnt_q + CNT_W'(1);
         else if (pop && !push)
            cnt_d = cnt_q - CNT_W'(1);
         ovf_d   = ovf_q | (print_hex_enable & full_q & ~pop);
         valid_d = (cnt_d != '0);
         full_d  = (cnt_d == CNT_W'(DEPTH));
         // New head is the word being written this cycle when the
         // write slot coincides with the next read slot.
         if (valid_d) begin
            if (push && (wr_ptr_q == rd_ptr_d))
               dout_d = print_output;
            else
               dout_d = mem_q[rd_ptr_d];
         end
      end
   end

   // Control and output registers
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         rd_ptr_q <= '0;
         wr_ptr_q <= '0;
         cnt_q    <= '0;
         dout_q   <= '0;
         valid_q  <= 1'b0;
         full_q   <= 1'b0;
         ovf_q    <= 1'b0;
         ack_q    <= 1'b0;
      end else begin
         rd_ptr_q <= rd_ptr_d;
         wr_ptr_q <= wr_ptr_d;
         cnt_q    <= cnt_d;
         dout_q   <= dout_d;
         valid_q  <= valid_d;
         full_q   <= full_d;
         ovf_q    <= ovf_d;
         ack_q    <= ack_d;
      end
   end

   // Storage array; contents are don't-care after reset
   always_ff @(posedge clk) begin
      if (wr_en)
         mem_q[wr_ptr_q] <= print_output;
   end

   assign data_out   = dout_q;
   assign data_valid = valid_q;
   assign fill_count = cnt_q;
   assign full       = full_q;
   assign overflow   = ovf_q;

endmodule

// File: doc/print_output_fifo.md
Name: print_output_fifo

Overview:
- Buffers print words from the Elpis output arbiter (print_hex_enable / print_output) for the host PicoRV on the management SoC.
- Sits directly downstream of the output arbiter, in place of its direct hookup to wbs_dat_o and la_data_out[100].
- The host drains one word per rising edge of an acknowledge bit driven over the logic analyzer.
- Decouples bursty core prints from slow host polling, and reports fill level and overflow.

Parameters:
- WIDTH, 32, print word width in bits.
- DEPTH, 8, number of FIFO entries; must be a power of two and at least 2.
- CNT_W, $clog2(DEPTH)+1, width of fill_count.

Ports:
- clk  in  1  system clock; the muxed LA/wishbone clock.
- reset  in  1  asynchronous, active-low reset.
- print_hex_enable  in  1  single-cycle push strobe from the output arbiter.
- print_output  in  WIDTH  print word, valid when print_hex_enable=1.
- host_ack  in  1  level from LA; a 0->1 edge pops the head word.
- host_clear  in  1  synchronous flush plus overflow clear; level, active-high.
- data_out  out  WIDTH  head-of-FIFO word, driven to wbs_dat_o.
- data_valid  out  1  FIFO non-empty; data_out is meaningful. Driven to la_data_out[100].
- fill_count  out  CNT_W  number of stored words, 0..DEPTH.
- full  out  1  fill_count == DEPTH.
- overflow  out  1  sticky flag: a push was dropped.

Behaviour:
- Reset (reset=0, asynchronous) clears the following; storage contents are don't-care:
  - rd_ptr, wr_ptr, fill_count
  - data_out=0, data_valid=0, full=0, overflow=0
  - ack_q=0
- Registered outputs: data_out, data_valid, fill_count, full and overflow all update on the clk rising edge only.
- Ack edge detect: ack_q <= host_ack every cycle. pop_req = host_ack & ~ack_q. Holding host_ack high pops exactly one word.
- Pop: pop = pop_req & data_valid. A pop_req while empty is ignored and has no side effects.
- Push acceptance: push = print_hex_enable & (~full | pop). Pushing while full in the same cycle as a pop is accepted, and the count stays at DEPTH.
- Overflow: print_hex_enable & full & ~pop sets overflow=1 and drops the word. Pointers and storage are unchanged.
- Flush: host_clear=1 has highest priority. In that cycle:
  - rd_ptr=wr_ptr=0, fill_count=0, data_valid=0, overflow=0.
  - A simultaneous push or pop is discarded.
- Count update:
  - push & ~pop: +1
  - pop & ~push: -1
  - both or neither: unchanged
- Pointers: log2(DEPTH) bits each. Natural wrap from DEPTH-1 to 0; no special case.
- Latency and ordering:
  - Push into an empty FIFO at edge N gives data_valid=1 with data_out equal to that word after edge N.
  - A pop at edge M presents the next word (or data_valid=0) after edge M.
  - Order is strict first-in, first-out.
- data_out hold rule: data_out holds its last value when data_valid=0. The host must not sample it then.
- Push into an empty FIFO concurrent with a pop_req: the pop is ignored (data_valid=0 at that edge) and the push is accepted.

Test Plan:
- Reset, then push 0xDEADBEEF and 0x00000001 on consecutive cycles -> one cycle after the first push data_valid=1, data_out=0xDEADBEEF, fill_count=1; next cycle fill_count=2.
- Hold host_ack high for 5 cycles with 2 words stored -> exactly one pop. data_out=0x00000001 and fill_count=1. Drop and re-raise host_ack -> data_valid=0, fill_count=0.
- Push 0x10..0x17 (8 words), then push 0x18 -> full=1, overflow=1, fill_count=8. Drain 8 acks -> reads 0x10..0x17 in order; 0x18 never appears.
- With FIFO full, issue an ack edge and a push of 0xAA in the same cycle -> push accepted, overflow unchanged, fill_count=8. The last word drained is 0xAA.
- Push 3 words, then host_clear=1 while also pushing 0x55 -> fill_count=0, data_valid=0, overflow=0. Next push 0x66 -> data_out=0x66, showing the pointers restarted at 0.
- Push 2 words, then assert reset=0 mid-cycle with no clk edge -> outputs clear immediately. Release reset, push 20 words with an ack each cycle -> pointers wrap correctly and output order matches input.
